// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine for the ALU's MULT/DIV/MULTU/DIVU ops.
// One operation in flight at a time; it returns a 64-bit hi/lo result with a one-cycle done pulse.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam logic [3:0] OP_MULT  = 4'ha;
  localparam logic [3:0] OP_DIV   = 4'hb;
  localparam logic [3:0] OP_MULTU = 4'hc;
  localparam logic [3:0] OP_DIVU  = 4'hd;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t state, state_nxt;

  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz_pend;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   mag0;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] acc;

  logic               op_valid;
  logic               op_is_div;
  logic               op_signed;
  logic               sign0;
  logic               sign1;
  logic               div_zero;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   abs0;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;

  always_comb begin
    op_valid  = (opcode == OP_MULT) || (opcode == OP_DIV) ||
                (opcode == OP_MULTU) || (opcode == OP_DIVU);
    op_is_div = (opcode == OP_DIV) || (opcode == OP_DIVU);
    op_signed = (opcode == OP_MULT) || (opcode == OP_DIV);
    sign0     = op_signed & data0[WIDTH-1];
    sign1     = op_signed & data1[WIDTH-1];
    abs0      = sign0 ? -data0 : data0;
    abs1      = sign1 ? -data1 : data1;
    div_zero  = op_is_div && (data1 == '0);
    accept    = (state == S_IDLE) && start && op_valid;
    last_step = (cnt == 6'(WIDTH - 1));

    // Multiply: add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag0} : '0);
    // Divide: trial-subtract the divisor from the shifted partial remainder; no borrow means quotient bit 1.
    div_trial = {rem, quo[WIDTH-1]} - {2'b00, mag1};
    div_ok    = ~div_trial[WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = div_zero ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_pend <= 1'b0;
      cnt      <= '0;
      mag0     <= '0;
      mag1     <= '0;
      quo      <= '0;
      rem      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_div   <= op_is_div;
            neg_q    <= sign0 ^ sign1;
            neg_r    <= sign0;
            dbz_pend <= div_zero;
            cnt      <= '0;
            busy     <= 1'b1;
            // A divide by zero skips CALC, so mag0 carries the raw dividend through to hi.
            mag0     <= div_zero ? data0 : abs0;
            mag1     <= abs1;
            acc      <= {{WIDTH{1'b0}}, abs1};
            quo      <= abs0;
            rem      <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
          if (op_div) begin
            rem <= div_ok ? div_trial[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          dbz  <= dbz_pend;
          if (dbz_pend) begin
            hi <= mag0;
            lo <= '1;
          end else if (op_div) begin
            hi <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            lo <= neg_q ? -quo : quo;
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of operations with hand-computed results,
// plus sequences for ignored starts, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .opcode(opcode),
    .data0 (data0),
    .data1 (data1),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_cyc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    opcode = op;
    data0  = a;
    data1  = b;
  endtask

  // Called at the negedge where start was driven; returns cycles until done is seen.
  // Cycles p1/p2 re-pulse start with a divide-by-zero DIVU that must be ignored.
  task automatic wait_done(input int p1, input int p2, output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_after_accept", 64'(busy), 64'd1);
      if (done) break;
      start  = (cyc == p1) || (cyc == p2);
      opcode = 4'hd;
      data0  = $urandom;
      data1  = start ? 32'd0 : $urandom;
    end
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic seen;

    vecs[0]  = '{4'hc, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[1]  = '{4'ha, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[2]  = '{4'ha, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[3]  = '{4'hb, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[4]  = '{4'hd, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[5]  = '{4'hb, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{4'hd, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vecs[7]  = '{4'hc, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34};
    vecs[8]  = '{4'hb, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    vecs[9]  = '{4'hb, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 34};
    vecs[10] = '{4'hb, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2};
    vecs[11] = '{4'hd, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34};
    vecs[12] = '{4'hd, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 34};
    vecs[13] = '{4'hc, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 34};
    vecs[14] = '{4'ha, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 34};
    vecs[15] = '{4'hc, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};

    rst    = 1'b1;
    start  = 1'b0;
    opcode = 4'h0;
    data0  = '0;
    data1  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    check("reset_dbz",  64'(dbz),  64'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, 0, cyc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i),  64'(hi),  64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i),  64'(lo),  64'(vecs[i].exp_lo));
      check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].exp_dbz));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // Mid-operation start pulses are ignored; an invalid opcode in the done cycle is not accepted.
    @(negedge clk);
    drive(4'hc, 32'h12345678, 32'h00000010);
    wait_done(5, 20, cyc);
    check("midstart_cycles", 64'(cyc), 64'd34);
    check("midstart_result", {hi, lo}, 64'h00000001_23456780);
    check("midstart_dbz", 64'(dbz), 64'd0);
    drive(4'h1, 32'd9, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", 64'(busy), 64'd0);
    check("badop_done", 64'(done), 64'd0);
    @(negedge clk);
    check("badop_busy2", 64'(busy), 64'd0);
    check("badop_hold", {hi, lo}, 64'h00000001_23456780);

    // Back-to-back: DIVU issued in the done cycle of a MULTU.
    drive(4'hc, 32'd6, 32'd7);
    wait_done(0, 0, cyc);
    check("b2b_first_cycles", 64'(cyc), 64'd34);
    check("b2b_first_lo", 64'(lo), 64'd42);
    drive(4'hd, 32'd1000, 32'd33);
    wait_done(0, 0, cyc);
    check("b2b_second_cycles", 64'(cyc), 64'd34);
    check("b2b_second_hi", 64'(hi), 64'd10);
    check("b2b_second_lo", 64'(lo), 64'd30);

    // Reset during CALC aborts with no done pulse and clears the outputs.
    @(negedge clk);
    drive(4'ha, 32'd5, 32'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi",   64'(hi),   64'd0);
    check("midrst_lo",   64'(lo),   64'd0);
    check("midrst_dbz",  64'(dbz),  64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    drive(4'ha, 32'd6, 32'd7);
    wait_done(0, 0, cyc);
    check("postrst_cycles", 64'(cyc), 64'd34);
    check("postrst_hi", 64'(hi), 64'd0);
    check("postrst_lo", 64'(lo), 64'd42);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative multi-cycle multiply/divide engine serving the ALU's MULT (4'ha), DIV (4'hb), MULTU (4'hc) and DIVU (4'hd) opcodes.
- The ALU issues an operation through a start/busy/done handshake; this unit returns a 64-bit result as hi/lo.
- It sits beside the ALU in the execute stage; the pipeline stalls on busy.

## Interface
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue request; sampled only in IDLE.
- opcode  in  4  4'ha MULT, 4'hb DIV, 4'hc MULTU, 4'hd DIVU; any other value with start is ignored.
- data0  in  WIDTH  multiplicand / dividend.
- data1  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo/dbz valid from this cycle.
- hi  out  WIDTH  product[63:32] / remainder.
- lo  out  WIDTH  product[31:0] / quotient.
- dbz  out  1  divide-by-zero flag for the last completed operation.

## Operation
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, dbz=0.
- Reset mid-operation aborts the operation with no done pulse.

States and transitions:
- IDLE: on start with a valid opcode, latch the opcode and go to CALC, or to FIX for a divide by zero.
  - Latch |data0| and |data1| (absolute value only for signed ops; unsigned ops use raw values).
  - Latch neg_q = sign0^sign1 and neg_r = sign0; both are 0 for unsigned ops.
  - Clear the 6-bit iteration counter; busy=1.
- CALC: one radix-2 step per cycle; counter increments; after step 31 (32 steps) go to FIX.
  - Multiply: shift-add on a 64-bit accumulator over the unsigned magnitudes.
  - Divide: restoring division with a 33-bit partial remainder; one quotient bit per step, MSB first.
- FIX, one cycle, then back to IDLE: write hi/lo, done=1, busy=0, and write dbz for this operation.
  - MULT: negate the 64-bit product if neg_q.
  - DIV: negate the quotient if neg_q and the remainder if neg_r.
  - Divide by zero (data1==0 on DIV/DIVU): hi=data0 unmodified, lo=all ones, dbz=1.
- hi/lo/dbz hold until the next FIX; done is low in every other cycle.

Arithmetic rules:
- All magnitudes are computed unsigned; results truncate to 64 bits for multiply and WIDTH bits each for quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, dbz=0; no trap.
- Remainder takes the dividend's sign; quotient truncates toward zero.
- start while busy is ignored; operands are not re-sampled.
- Operands are captured at acceptance; data0/data1 may change afterward without effect.

## Timing
- Acceptance edge E0; CALC occupies edges E1..E32; FIX at edge E33.
- done is high for the cycle after E33: 34 cycles from start to done.
- Divide by zero: FIX at E1, so done is high 2 cycles after start.
- busy rises after E0 and falls on the same edge done rises.
- start asserted during the done cycle is accepted, giving back-to-back operations with 0 idle cycles.
- Throughput is one operation per 34 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001, dbz=0.
- MULT 0xFFFFFFFD (-3) × 7, then 0x80000000 × 0x80000000 -> hi/lo=0xFFFFFFFF/0xFFFFFFEB, then 0x40000000/0x00000000.
- DIV -7 / 2, then DIVU 100 / 7, then DIV 0x80000000 / -1:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - then lo=14, hi=2;
  - then lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> done 2 cycles after start; hi=0x1234, lo=0xFFFFFFFF, dbz=1; next valid op clears dbz.
- start pulsed at cycles 5 and 20 of a MULTU, then at its done cycle with opcode 4'h1, then with DIVU -> mid-op pulses ignored, result unchanged; opcode 4'h1 gives no busy; DIVU accepted in the done cycle.
- rst asserted at CALC step 10, then a new MULT 6×7 -> busy=0, done=0, hi=lo=0 after the reset edge; new op yields lo=42, hi=0 at 34 cycles.
